// File: rtl/cam_stream_gen.sv
// -----------------------------------------------------------------------------
// cam_stream_gen
// Camera emulator for an OV7670-style parallel pixel bus. Reads an RGB332
// frame from a synchronous frame-buffer port, expands each pixel to RGB565 and
// emits it as two bytes per pixel with vsync/href frame timing.
//
// Ports:
//   pclk         pixel clock, all logic on its rising edge
//   rst          synchronous active-high reset
//   enable       run request, sampled only at frame boundaries
//   mem_px_addr  frame-buffer read address (linear pixel index)
//   mem_px_data  RGB332 pixel {R[2:0],G[2:0],B[1:0]}, valid one cycle after addr
//   vsync        frame sync, active high
//   href         line valid, high while px_data carries pixel bytes
//   px_data      RGB565 byte stream (byte 1 = {R5,G6[5:3]}, byte 2 = {G6[2:0],B5})
//   frame_done   one-cycle pulse after the end of a frame
//
// The FSM state and hcnt/vcnt describe the current timing slot; vsync, href,
// px_data and frame_done are registered from that slot, so all outputs lag the
// counters by one cycle and stay mutually aligned.
// -----------------------------------------------------------------------------
module cam_stream_gen #(
  parameter int AW          = 15,
  parameter int H_PIX       = 160,
  parameter int V_LINES     = 120,
  parameter int H_BLANK     = 16,
  parameter int VSYNC_LINES = 3,
  parameter int V_BP        = 2,
  parameter int V_FP        = 2
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          enable,
  output logic [AW-1:0] mem_px_addr,
  input  logic [7:0]    mem_px_data,
  output logic          vsync,
  output logic          href,
  output logic [7:0]    px_data,
  output logic          frame_done
);

  localparam int LINE_LEN    = 2 * H_PIX + H_BLANK;
  localparam int FRAME_LINES = VSYNC_LINES + V_BP + V_LINES + V_FP;
  localparam int HW          = $clog2(LINE_LEN);
  localparam int VW          = $clog2(FRAME_LINES);
  localparam int NPIX        = H_PIX * V_LINES;

  localparam logic [HW-1:0] H_LAST    = HW'(LINE_LEN - 1);
  localparam logic [HW-1:0] H_ACT     = HW'(2 * H_PIX);
  localparam logic [VW-1:0] VS_END    = VW'(VSYNC_LINES - 1);
  localparam logic [VW-1:0] VBP_END   = VW'(VSYNC_LINES + V_BP - 1);
  localparam logic [VW-1:0] ACT_END   = VW'(VSYNC_LINES + V_BP + V_LINES - 1);
  localparam logic [VW-1:0] FRAME_END = VW'(FRAME_LINES - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(NPIX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBP,
    S_ACTIVE,
    S_VFP
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [7:0]    byte2_q;
  logic          line_end;
  logic          frame_end;
  logic          in_act;
  logic [15:0]   rgb565;

  // Bit-replicating RGB332 -> RGB565 expansion.
  function automatic logic [15:0] expand_332(input logic [7:0] p);
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    r5 = {p[7:5], p[7:6]};
    g6 = {p[4:2], p[4:2]};
    b5 = {p[1:0], p[1:0], p[1]};
    return {r5, g6, b5};
  endfunction

  assign rgb565 = expand_332(mem_px_data);

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    line_end  = (hcnt == H_LAST);
    frame_end = (state_q == S_VFP) && line_end && (vcnt == FRAME_END);
    in_act    = (state_q == S_ACTIVE) && (hcnt < H_ACT);
    case (state_q)
      S_IDLE:   if (enable) state_d = S_VSYNC;
      S_VSYNC:  if (line_end && vcnt == VS_END)  state_d = S_VBP;
      S_VBP:    if (line_end && vcnt == VBP_END) state_d = S_ACTIVE;
      S_ACTIVE: if (line_end && vcnt == ACT_END) state_d = S_VFP;
      S_VFP:    if (frame_end) state_d = enable ? S_VSYNC : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hcnt        <= '0;
      vcnt        <= '0;
      vsync       <= 1'b0;
      href        <= 1'b0;
      px_data     <= 8'h00;
      byte2_q     <= 8'h00;
      frame_done  <= 1'b0;
      mem_px_addr <= '0;
    end else begin
      state_q <= state_d;

      // Timing counters; parked at zero while idle so a frame always starts
      // at hcnt = vcnt = 0.
      if (state_q == S_IDLE) begin
        hcnt <= '0;
        vcnt <= '0;
      end else if (line_end) begin
        hcnt <= '0;
        vcnt <= frame_end ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end

      vsync      <= (state_q == S_VSYNC);
      href       <= in_act;
      frame_done <= frame_end;

      // Even slots sample the RAM word and launch byte 1 while parking byte 2;
      // the address steps on that same edge, so the next pixel's address is
      // presented for two full cycles before its byte 1 is launched. The
      // address set during the last pixel of a line carries over the blank
      // tail into the next line, and wraps to 0 after the frame's last pixel.
      if (in_act) begin
        if (!hcnt[0]) begin
          px_data     <= rgb565[15:8];
          byte2_q     <= rgb565[7:0];
          mem_px_addr <= (mem_px_addr == ADDR_LAST) ? '0 : mem_px_addr + 1'b1;
        end else begin
          px_data <= byte2_q;
        end
      end else begin
        px_data <= 8'h00;
      end
    end
  end

endmodule

// File: doc/cam_stream_gen.md
Name: cam_stream_gen

Overview:
- Camera-side transmitter for the OV7670-style parallel pixel bus (vsync, href, 8-bit px_data) consumed by the capture block cam_read.
- Reads an RGB332 frame from a synchronous frame-buffer port, expands each pixel to RGB565 and emits it as two bytes per pixel with full vsync/href frame timing.
- Used as a camera emulator for loopback bring-up and as the stimulus source in capture testbenches.

Parameters:
- AW, 15: frame-buffer address width.
- H_PIX, 160: active pixels per line (2*H_PIX bytes per line).
- V_LINES, 120: active lines per frame.
- H_BLANK, 16: href-low cycles after each line's bytes (≥2).
- VSYNC_LINES, 3: line periods with vsync high at frame start.
- V_BP, 2: blank line periods after vsync, before the first active line.
- V_FP, 2: blank line periods after the last active line.

Ports:
- pclk  in  1  pixel clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  run request; sampled only at frame boundaries.
- mem_px_addr  out  AW  frame-buffer read address, linear pixel index.
- mem_px_data  in  8  RGB332 pixel {R[2:0],G[2:0],B[1:0]}; valid one cycle after mem_px_addr (synchronous RAM).
- vsync  out  1  frame sync, active high.
- href  out  1  line valid, high while px_data carries pixel bytes.
- px_data  out  8  RGB565 byte stream.
- frame_done  out  1  one-cycle pulse after the last byte of a frame.

Behaviour:
- Reset: vsync=0, href=0, px_data=0, mem_px_addr=0, frame_done=0, state IDLE, counters 0. Reset mid-frame aborts immediately. No partial line completes.
- Timing: line period L = 2*H_PIX+H_BLANK cycles, counted by hcnt 0..L-1. Frame = VSYNC_LINES+V_BP+V_LINES+V_FP line periods, counted by vcnt.
- State machine:
  - IDLE: outputs low; when enable=1, go to VSYNC at hcnt=vcnt=0.
  - VSYNC: vsync=1 for VSYNC_LINES*L cycles, then VBP.
  - VBP: vsync=0, href=0 for V_BP*L cycles, then ACTIVE.
  - ACTIVE: per line, href=1 for hcnt<2*H_PIX and 0 for the H_BLANK tail. Runs V_LINES lines, then VFP.
  - VFP: V_FP*L cycles, all low. At the end, frame_done pulses for one cycle. Then go to VSYNC if enable=1, else IDLE.
- Output registering: vsync, href and px_data are registered and mutually aligned. Within an href-high run, even byte slots carry byte 1 and odd slots carry byte 2.
- RGB332 to RGB565 expansion by bit replication:
  - R5={R,R[2:1]}, G6={G,G}, B5={B,B,B[1]}.
  - Byte 1={R5,G6[5:3]}, byte 2={G6[2:0],B5}.
  - Both bytes come from one sampled mem_px_data. Byte 2 is held in a register.
- Addressing:
  - mem_px_addr=0 at VBP entry. It holds pixel p for at least one full cycle before the edge launching byte 1 of p.
  - It advances by 1 per pixel, continuous across lines: line k starts at k*H_PIX.
  - After pixel H_PIX*V_LINES-1 it returns to 0 and holds there through VFP/VSYNC.
- px_data=0 whenever href=0.
- enable: deassertion mid-frame has no effect until frame_done. enable=0 in IDLE stays in IDLE.
- Total active bytes per frame: exactly 2*H_PIX*V_LINES. No extra or missing bytes at line or frame edges.

Test Plan:
- Reset/idle: rst=1 for 3 cycles, enable=0 → all outputs 0 indefinitely, mem_px_addr=0.
- Frame timing (H_PIX=4, V_LINES=3, H_BLANK=2, VSYNC_LINES=1, V_BP=1, V_FP=1, so L=10, frame=60 cycles) → vsync high 10 cycles; 3 href pulses of 8 cycles, each spaced 10 cycles; frame_done at frame end; next vsync rises exactly 60 cycles after the previous one.
- Colour expansion, RAM model returning the pixel sequence:
  - 8'hE0 → F8,00
  - 8'h1C → 07,E0
  - 8'h03 → 00,1F
  - 8'hFF → FF,FF
  - 8'h00 → 00,00
- Address sequence: RAM returns data = address → byte pairs decode to pixels 0..11 in order; mem_px_addr wraps to 0 after pixel 11.
- enable dropped mid-ACTIVE → current frame completes with all 24 bytes, frame_done pulses, then IDLE. Re-asserting enable → new frame starts with vsync.
- Loopback into cam_read with default parameters and random RAM contents → captured RGB332 equals the source for all 19200 pixels. rst pulsed mid-line → outputs 0 on the next cycle, restart from IDLE.
